// File: rtl/mem_access_stage.sv
// MIPS III memory-access stage: EX/MEM register, single-outstanding req/ack data port,
// big-endian byte/halfword alignment, LL/SC link tracking, address/trap exceptions, MEM/WB register.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Trap,
  input  logic        TrapCond,
  input  logic        LLSC,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [4:0]  RegDstOut,
  output logic        MemStall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_Valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [4:0]  wb_RegDst,
  output logic [31:0] wb_ALUResult,
  output logic [31:0] wb_ReadData,
  output logic        ExcAdEL,
  output logic        ExcAdES,
  output logic        ExcTr,
  output logic [31:0] BadVAddr,
  output logic        dbgState
);

  // Memory handshake: dmem_req and all dmem_* outputs stay stable from the first request
  // cycle through the cycle dmem_ack is high; one access is outstanding at a time and an
  // abandoned request (flush/reset) simply drops dmem_req.
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  state_t      state, nextState;
  logic        exValid, exTrap, exTrapCond, exLLSC, exMemRead, exMemWrite;
  logic        exMemHalf, exMemByte, exSignExt, exRegWrite, exMemtoReg;
  logic [31:0] exAddr, exWdata;
  logic [4:0]  exRegDst;
  logic        llBit;
  logic [31:0] llAddr;
  logic [31:0] holdData;
  logic        adv, misaligned, exc, isSc, scOk, memop, ackTaken;
  logic [1:0]  off;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] alignedRdata, wbData;

  assign off        = exAddr[1:0];
  assign misaligned = exMemByte ? 1'b0 : (exMemHalf ? off[0] : (off != 2'b00));
  assign ExcAdEL    = exMemRead && misaligned;
  assign ExcAdES    = exMemWrite && misaligned;
  assign ExcTr      = exTrap && ((exAddr != 32'd0) == exTrapCond);
  assign exc        = ExcAdEL || ExcAdES || ExcTr;
  assign BadVAddr   = exAddr;

  // A store-conditional only reaches memory when the link still covers its address.
  assign isSc  = exLLSC && exMemWrite;
  assign scOk  = llBit && (llAddr == exAddr);
  assign memop = exMemRead || (exMemWrite && (!exLLSC || scOk));

  assign MemStall = (state == IDLE) && dmem_req && !dmem_ack;
  assign adv      = !Stall && !MemStall;
  assign ackTaken = (state == IDLE) && dmem_req && dmem_ack;
  assign dbgState = state;

  assign dmem_we    = dmem_req && exMemWrite;
  assign dmem_addr  = {exAddr[31:2], 2'b00};
  assign dmem_be    = exMemByte ? (4'b1000 >> off) :
                      exMemHalf ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign dmem_wdata = exMemByte ? {4{exWdata[7:0]}} :
                      exMemHalf ? {2{exWdata[15:0]}} : exWdata;

  always_comb begin
    dmem_req  = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        dmem_req = memop && !exc;
        if (dmem_req && dmem_ack && !adv) nextState = DONE;
      end
      DONE: begin
        if (adv) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rdByte = dmem_rdata[31:24];
    case (off)
      2'd0: rdByte = dmem_rdata[31:24];
      2'd1: rdByte = dmem_rdata[23:16];
      2'd2: rdByte = dmem_rdata[15:8];
      2'd3: rdByte = dmem_rdata[7:0];
      default: rdByte = dmem_rdata[31:24];
    endcase
    rdHalf = off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    if (exMemByte)      alignedRdata = {{24{exSignExt & rdByte[7]}}, rdByte};
    else if (exMemHalf) alignedRdata = {{16{exSignExt & rdHalf[15]}}, rdHalf};
    else                alignedRdata = dmem_rdata;
  end

  assign wbData = isSc ? {31'd0, scOk} : ((state == DONE) ? holdData : alignedRdata);

  always_ff @(posedge clk) begin
    if (rst || Flush) state <= IDLE;
    else              state <= nextState;
  end

  // Flush clears only the control bits; the address is kept so BadVAddr stays meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      exValid <= 1'b0; exTrap <= 1'b0; exTrapCond <= 1'b0; exLLSC <= 1'b0;
      exMemRead <= 1'b0; exMemWrite <= 1'b0; exMemHalf <= 1'b0; exMemByte <= 1'b0;
      exSignExt <= 1'b0; exRegWrite <= 1'b0; exMemtoReg <= 1'b0;
      exAddr <= 32'd0; exWdata <= 32'd0; exRegDst <= 5'd0;
    end else if (Flush) begin
      exValid <= 1'b0; exTrap <= 1'b0; exTrapCond <= 1'b0; exLLSC <= 1'b0;
      exMemRead <= 1'b0; exMemWrite <= 1'b0; exMemHalf <= 1'b0; exMemByte <= 1'b0;
      exSignExt <= 1'b0; exRegWrite <= 1'b0; exMemtoReg <= 1'b0;
    end else if (adv) begin
      exValid <= 1'b1; exTrap <= Trap; exTrapCond <= TrapCond; exLLSC <= LLSC;
      exMemRead <= MemRead; exMemWrite <= MemWrite; exMemHalf <= MemHalf;
      exMemByte <= MemByte; exSignExt <= MemSignExtend; exRegWrite <= RegWrite;
      exMemtoReg <= MemtoReg; exAddr <= ALUResult; exWdata <= ReadData2;
      exRegDst <= RegDstOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  holdData <= 32'd0;
    else if (ackTaken && (nextState == DONE)) holdData <= alignedRdata;
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      llBit  <= 1'b0;
      llAddr <= 32'd0;
    end else if (ackTaken && exLLSC && exMemRead) begin
      llBit  <= 1'b1;
      llAddr <= exAddr;
    end else if (adv && isSc) begin
      llBit  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_Valid <= 1'b0; wb_RegWrite <= 1'b0; wb_MemtoReg <= 1'b0;
      wb_RegDst <= 5'd0; wb_ALUResult <= 32'd0; wb_ReadData <= 32'd0;
    end else if (!Stall) begin
      if (Flush || MemStall) begin
        wb_Valid <= 1'b0; wb_RegWrite <= 1'b0; wb_MemtoReg <= 1'b0;
      end else begin
        wb_Valid     <= exValid;
        wb_RegWrite  <= exRegWrite && !exc;
        wb_MemtoReg  <= exMemtoReg || isSc;
        wb_RegDst    <= exRegDst;
        wb_ALUResult <= exAddr;
        wb_ReadData  <= wbData;
      end
    end
  end

endmodule
